stack_memory: RTL and testbench

Data-stack storage for the single-cycle stack machine, sitting directly downstream of the stack pointer register. It takes the current stack pointer and the per-instruction stack update mode, and presents top-of-stack (TOS) and next-on-stack (NOS) operands combinationally. On each clock edge it commits the instruction's result word to the slot implied by the mode. It also keeps a sticky overflow/underflow fault and a high-watermark of stack occupancy for debug.

---
 rtl/stack_memory_if.sv | 26 ++
 rtl/stack_memory.sv | 115 +++++++++++
 tb/tb_stack_memory.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/stack_memory_if.sv
// Operand/result bundle between the stack machine datapath and its stack storage.
interface stack_memory_if #(
    parameter int unsigned REG_BITS  = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_BITS = $clog2(DEPTH)
);
    logic [REG_BITS-1:0]  SP_in;
    logic [1:0]           StackUpdateMode;
    logic                 WriteEn;
    logic [REG_BITS-1:0]  WriteData;
    logic [REG_BITS-1:0]  TOS;
    logic [REG_BITS-1:0]  NOS;
    logic                 StackFault;
    logic [1:0]           FaultCode;
    logic [ADDR_BITS:0]   HighWater;

    modport master (
        output SP_in, StackUpdateMode, WriteEn, WriteData,
        input  TOS, NOS, StackFault, FaultCode, HighWater
    );

    modport slave (
        input  SP_in, StackUpdateMode, WriteEn, WriteData,
        output TOS, NOS, StackFault, FaultCode, HighWater
    );
endinterface

// File: rtl/stack_memory.sv
// Data-stack storage: combinational TOS/NOS reads, mode-addressed write, sticky fault, high-water.
// Bounds checking and write suppression are built only with STACK_BOUNDS_CHECK_EN defined.
module stack_memory #(
    parameter int unsigned REG_BITS  = 32,
    parameter int unsigned DEPTH     = 16,
    localparam int unsigned ADDR_BITS = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    stack_memory_if.slave bus
);

    localparam logic [1:0] ModeUnary  = 2'b00;
    localparam logic [1:0] ModePush   = 2'b01;
    localparam logic [1:0] ModePop2   = 2'b10;
    localparam logic [1:0] ModeBinary = 2'b11;

    typedef logic [ADDR_BITS-1:0] idx_t;

    logic [REG_BITS-1:0] mem_q [DEPTH];
    logic [ADDR_BITS:0]  hw_q;
    logic [REG_BITS-1:0] sp;
    logic [1:0]          mode;
    idx_t                tos_idx;
    idx_t                nos_idx;
    idx_t                wr_idx;
    logic                write_req;
    logic                wr_en;
    logic [ADDR_BITS:0]  sp_lo;

    assign sp        = bus.SP_in;
    assign mode      = bus.StackUpdateMode;
    assign tos_idx   = sp[ADDR_BITS-1:0] - idx_t'(1);
    assign nos_idx   = sp[ADDR_BITS-1:0] - idx_t'(2);
    assign sp_lo     = sp[ADDR_BITS:0];
    assign write_req = bus.WriteEn && (mode != ModePop2);

    always_comb begin
        wr_idx = sp[ADDR_BITS-1:0];
        case (mode)
            ModeUnary:  wr_idx = tos_idx;
            ModeBinary: wr_idx = nos_idx;
            default:    wr_idx = sp[ADDR_BITS-1:0];
        endcase
    end

`ifdef STACK_BOUNDS_CHECK_EN
    localparam logic [REG_BITS-1:0] DepthW = REG_BITS'(DEPTH);

    logic       overflow;
    logic       underflow;
    logic       fault_now;
    logic       fault_q;
    logic [1:0] code_q;

    always_comb begin
        overflow  = (sp > DepthW) || ((sp == DepthW) && (mode == ModePush));
        underflow = 1'b0;
        case (mode)
            ModeUnary: underflow = (sp < REG_BITS'(1));
            ModePush:  underflow = 1'b0;
            default:   underflow = (sp < REG_BITS'(2));
        endcase
    end

    assign fault_now = overflow || underflow;
    assign wr_en     = write_req && !fault_now;

    assign bus.TOS        = (sp >= REG_BITS'(1)) ? mem_q[tos_idx] : '0;
    assign bus.NOS        = (sp >= REG_BITS'(2)) ? mem_q[nos_idx] : '0;
    assign bus.StackFault = fault_q;
    assign bus.FaultCode  = code_q;

    // Only the first fault is recorded; later ones leave the code alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
            code_q  <= 2'b00;
        end else if (!fault_q && fault_now) begin
            fault_q <= 1'b1;
            code_q  <= overflow ? 2'b01 : 2'b10;
        end
    end
`else
    logic unused_sp_hi;

    assign unused_sp_hi   = ^sp[REG_BITS-1:ADDR_BITS+1];
    assign wr_en          = write_req;
    assign bus.TOS        = mem_q[tos_idx];
    assign bus.NOS        = mem_q[nos_idx];
    assign bus.StackFault = 1'b0;
    assign bus.FaultCode  = 2'b00;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= bus.WriteData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hw_q <= '0;
        end else if (sp_lo > hw_q) begin
            hw_q <= sp_lo;
        end
    end

    assign bus.HighWater = hw_q;

endmodule

// File: tb/tb_stack_memory.sv
// Scoreboard bench for stack_memory: directed test-plan steps, then randomized traffic.
module tb_stack_memory;
    localparam int unsigned D = 16;

    typedef struct {
        string       name;
        logic [31:0] tos;
        logic [31:0] nos;
        logic        flt;
        logic [1:0]  code;
        logic [4:0]  hw;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   passes = 0;
    exp_t exp_q[$];

    logic [31:0] m_mem [D];
    logic        m_flt;
    logic [1:0]  m_code;
    logic [4:0]  m_hw;

    stack_memory_if #(.REG_BITS(32), .DEPTH(D)) bus ();

    stack_memory #(.REG_BITS(32), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] sp, input logic [31:0] back);
        logic [31:0] a;
        a = sp - back;
`ifdef STACK_BOUNDS_CHECK_EN
        if (sp < back) return 32'h0;
`endif
        return m_mem[a[3:0]];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < int'(D); i++) m_mem[i] = 32'h0;
        m_flt  = 1'b0;
        m_code = 2'b00;
        m_hw   = 5'd0;
    endtask

    task automatic model_commit(input logic [31:0] sp, input logic [1:0] mode,
                                input logic we, input logic [31:0] data);
        logic [31:0] slot;
        logic [1:0]  f;
        int unsigned need;
        f    = 2'b00;
        need = (mode == 2'b00) ? 1 : (mode == 2'b01) ? 0 : 2;
`ifdef STACK_BOUNDS_CHECK_EN
        if (sp > D || (sp == D && mode == 2'b01)) f = 2'b01;
        else if (sp < need) f = 2'b10;
        if (f != 2'b00 && !m_flt) begin
            m_flt  = 1'b1;
            m_code = f;
        end
`endif
        slot = (mode == 2'b00) ? sp - 1 : (mode == 2'b11) ? sp - 2 : sp;
        if (we && mode != 2'b10 && f == 2'b00) m_mem[slot % D] = data;
        if ((sp % (2 * D)) > m_hw) m_hw = 5'(sp % (2 * D));
    endtask

    // Drive one cycle's inputs, queue the expected outputs, then let the edge commit.
    task automatic apply(input logic [31:0] sp, input logic [1:0] mode, input logic we,
                         input logic [31:0] data, input string nm);
        exp_t e;
        bus.SP_in           = sp;
        bus.StackUpdateMode = mode;
        bus.WriteEn         = we;
        bus.WriteData       = data;
        e.name = nm;
        e.tos  = m_read(sp, 1);
        e.nos  = m_read(sp, 2);
        e.flt  = m_flt;
        e.code = m_code;
        e.hw   = m_hw;
        exp_q.push_back(e);
        @(posedge clk);
        model_commit(sp, mode, we, data);
        #1;
    endtask

    // Reset lands while a push is on the bus; that write must be discarded.
    task automatic do_reset();
        bus.SP_in           = 32'd0;
        bus.StackUpdateMode = 2'b01;
        bus.WriteEn         = 1'b1;
        bus.WriteData       = 32'hDEAD_BEEF;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.name, ".tos"},  bus.TOS,               e.tos);
                chk({e.name, ".nos"},  bus.NOS,               e.nos);
                chk({e.name, ".flt"},  32'(bus.StackFault),   32'(e.flt));
                chk({e.name, ".code"}, 32'(bus.FaultCode),    32'(e.code));
                chk({e.name, ".hw"},   32'(bus.HighWater),    32'(e.hw));
            end
        end
    end

    initial begin : stimulus
        logic [31:0] sp;
        bus.SP_in           = 32'd0;
        bus.StackUpdateMode = 2'b00;
        bus.WriteEn         = 1'b0;
        bus.WriteData       = 32'd0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        apply(32'd0,  2'b01, 1'b1, 32'd5,  "reset_push5");
        apply(32'd1,  2'b01, 1'b1, 32'd7,  "push7");
        apply(32'd2,  2'b11, 1'b1, 32'd12, "binary12");
        apply(32'd1,  2'b00, 1'b0, 32'd0,  "after_binary");
        apply(32'd16, 2'b01, 1'b1, 32'd9,  "overflow_push");
        apply(32'd0,  2'b10, 1'b0, 32'd0,  "later_underflow");
        apply(32'd2,  2'b00, 1'b0, 32'd0,  "code_sticky");

        do_reset();
        apply(32'd1,  2'b10, 1'b1, 32'd77, "pop2_underflow");
        apply(32'd2,  2'b00, 1'b0, 32'd0,  "mem_unchanged");

        do_reset();
        apply(32'd16, 2'b01, 1'b1, 32'd3,  "wrap_push");
        apply(32'd1,  2'b00, 1'b0, 32'd0,  "wrap_tos");
        apply(32'd0,  2'b00, 1'b0, 32'd0,  "sp0_read");

        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 50) do_reset();
            sp = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 17));
            apply(sp, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), $urandom, "rand");
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
